fifo_replay: RTL
================

Name: fifo_replay

Overview:
Parametrised successor to the team's single-channel FIFO. Supports any DEPTH ≥ 2 (not only powers of two), with wrapping pointers and a valid/ready handshake on both sides. Adds a circular replay mode: reads walk the stored contents repeatedly without consuming them. Used as a stream buffer and as a pattern-replay store in front of DAC/test-pattern paths.

Parameters:
WIDTH, 32, data word width in bits (≥1)
DEPTH, 32, storage entries (≥2, any integer)
ALMOSTFULL, 1, almostFull asserts when free entries ≤ ALMOSTFULL
ALMOSTEMPTY, 1, almostEmpty asserts when fill ≤ ALMOSTEMPTY

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of contents (pointers, fill, output stage)
circular  in  1  1 = replay mode (reads do not consume), 0 = normal FIFO
rewind  in  1  in circular mode, restart replay from oldest entry
inData  in  WIDTH  write data
inValid  in  1  write request
inReady  out  1  space available; a write is accepted when inValid && inReady
outData  out  WIDTH  head/replay data, valid when outValid
outValid  out  1  outData holds a word
outReady  in  1  a read is accepted when outValid && outReady
fillLevel  out  $clog2(DEPTH+1)  stored entries, 0..DEPTH
empty, almostEmpty, full, almostFull  out  1 each  registered status
overflow, underflow  out  1 each  sticky error flags (see Optional Feature)
clearErrors  in  1  synchronous clear of the sticky flags

Behaviour:
- Reset is asynchronous and active-low.
- Reset (reset=0), async: all pointers, fill, and outValid = 0; empty = 1, almostEmpty = 1, full = 0, almostFull = (DEPTH ≤ ALMOSTFULL); overflow = underflow = 0; outData = 0.
- flush=1: same values as reset on the next edge. flush has priority over all other inputs in that cycle.
- Pointers: wrPtr, beginPtr, and rdPtr, each $clog2(DEPTH) bits. Increment wraps DEPTH-1 → 0 explicitly (no power-of-two aliasing).
- inReady = !full (registered). A write is never accepted when full, even with a simultaneous read (no pass-through).
- Normal mode (circular=0):
  - An accepted write stores at wrPtr and increments wrPtr.
  - An accepted read increments beginPtr, and rdPtr = beginPtr.
  - fill: +1 on write only, −1 on read only, unchanged on both.
- Output stage is a registered show-ahead:
  - A word written into an empty FIFO appears at outValid/outData on the next cycle (latency 1).
  - After an accepted read, the next word is presented the following cycle with no bubble when fill > 1.
- Circular mode (circular=1):
  - An accepted read increments rdPtr only. fill and beginPtr are unchanged.
  - When rdPtr+1 would equal wrPtr, rdPtr wraps to beginPtr.
  - Writes are still accepted and appended, joining the loop on the next pass.
  - outValid = (fill ≠ 0).
- rewind=1 with circular=1: rdPtr ← beginPtr and outData reloads the oldest entry next cycle. outValid stays high if fill ≠ 0. A read accepted in the same cycle is discarded (rewind wins). rewind is ignored when circular=0.
- circular 1→0: rdPtr ← beginPtr, and outValid is forced 0 for exactly one cycle while the head reloads.
- Status flags are registered from the updated fill (same edge as fillLevel):
  - empty = fill==0, full = fill==DEPTH
  - almostEmpty = fill ≤ ALMOSTEMPTY, almostFull = DEPTH−fill ≤ ALMOSTFULL
- Reset mid-operation: contents are lost. Memory is not cleared, but it is unobservable because outValid=0.

Optional Feature:
FIFO_STICKY_ERR_EN
- Defined:
  - overflow sets on inValid && !inReady.
  - underflow sets on outReady && !outValid while circular=0.
  - Both stay set until clearErrors or reset/flush.
- Undefined: overflow and underflow are tied 0, clearErrors is ignored, and no error logic is synthesised.

Decomposition:
- Shared package fifo_pkg contains:
  - fill_status_t struct (empty, almostEmpty, full, almostFull)
  - function fill_bits(depth) = $clog2(depth+1)
  - function ptr_bits(depth) = max(1, $clog2(depth))
- One sub-module, fifo_ptr_wrap: a modulo-DEPTH pointer register with inc and load inputs (load used for rewind/flush). It is instantiated three times.

Test Plan:
1. DEPTH=5, normal mode: write 1..5 → full=1, inReady=0; 6th write held; then read 5 → outputs 1,2,3,4,5; empty=1; wrPtr wrapped to 0.
2. Empty FIFO, write 0xA5 at cycle t → outValid=1, outData=0xA5 at t+1. Simultaneous read+write at fill=3 → fillLevel stays 3.
3. Circular: load 3,7,9; circular=1, outReady held 1 for 7 reads → 3,7,9,3,7,9,3; fillLevel stays 3.
4. Circular after reading 3,7: rewind together with outReady → next outData=3, no advance that cycle.
5. Assert reset low while fill=4 mid-stream → outValid=0, fillLevel=0, empty=1 immediately (async); flush=1 gives the same values on the next edge.
6. With FIFO_STICKY_ERR_EN: write while full → overflow=1 persists; clearErrors → 0. Without the macro, overflow stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the replay FIFO family.
package fifo_pkg;

  typedef struct packed {
    logic empty;
    logic almostEmpty;
    logic full;
    logic almostFull;
  } fill_status_t;

  // Width needed to hold a fill count of 0..depth.
  function automatic int fill_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a modulo-depth pointer; never narrower than one bit.
  function automatic int ptr_bits(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer register: increments wrap DEPTH-1 -> 0 explicitly,
// so non-power-of-two depths never alias. load has priority over inc.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PW    = ptr_bits(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  output logic [PW-1:0] ptr,
  output logic [PW-1:0] nxt
);

  logic [PW-1:0] plus;

  // Next pointer value: load wins, otherwise wrap-aware increment.
  always_comb begin
    plus = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    nxt  = ptr;
    if (load)
      nxt = load_val;
    else if (inc)
      nxt = plus;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr <= '0;
    else
      ptr <= nxt;
  end

endmodule

// File: rtl/fifo_replay.sv
// Parametrised FIFO with registered show-ahead output and a circular
// replay mode in which reads walk the stored words without consuming them.
// Optional sticky overflow/underflow flags: define FIFO_STICKY_ERR_EN.
module fifo_replay
  import fifo_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 32,
  parameter int ALMOSTFULL  = 1,
  parameter int ALMOSTEMPTY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       circular,
  input  logic                       rewind,
  input  logic [WIDTH-1:0]           inData,
  input  logic                       inValid,
  output logic                       inReady,
  output logic [WIDTH-1:0]           outData,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [fill_bits(DEPTH)-1:0] fillLevel,
  output logic                       empty,
  output logic                       almostEmpty,
  output logic                       full,
  output logic                       almostFull,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clearErrors
);

  localparam int PW = ptr_bits(DEPTH);
  localparam int FW = fill_bits(DEPTH);

  function automatic fill_status_t status_of(input logic [FW-1:0] f);
    fill_status_t s;
    s.empty       = (f == '0);
    s.almostEmpty = (int'(f) <= ALMOSTEMPTY);
    s.full        = (int'(f) == DEPTH);
    s.almostFull  = ((DEPTH - int'(f)) <= ALMOSTFULL);
    return s;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr, begin_ptr, rd_ptr;
  logic [PW-1:0]    begin_nxt, rd_nxt, rd_plus;
  logic [PW-1:0]    unused_wr_nxt;
  logic             mode_q;
  logic             wr_acc, rd_acc, pop, adv, leave, rd_load;
  logic [FW-1:0]    fill_q, fill_nxt;
  fill_status_t     st_q, st_nxt;
  logic             ov_nxt;
  logic [WIDTH-1:0] od_nxt;

  assign inReady     = !st_q.full;
  assign empty       = st_q.empty;
  assign almostEmpty = st_q.almostEmpty;
  assign full        = st_q.full;
  assign almostFull  = st_q.almostFull;
  assign fillLevel   = fill_q;

  // Handshake decode. In the cycle circular drops (mode_q still 1) the
  // presented word is a replay word, so a read there is discarded.
  always_comb begin
    wr_acc  = inValid && inReady;
    rd_acc  = outValid && outReady;
    leave   = mode_q && !circular;
    pop     = rd_acc && !circular && !mode_q;
    adv     = rd_acc && circular && !rewind;
    rd_plus = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    rd_load = flush || !circular || rewind || (adv && (rd_plus == wr_ptr));
  end

  fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_wr (
    .clk(clk), .reset(reset), .inc(wr_acc), .load(flush),
    .load_val('0), .ptr(wr_ptr), .nxt(unused_wr_nxt)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_begin (
    .clk(clk), .reset(reset), .inc(pop), .load(flush),
    .load_val('0), .ptr(begin_ptr), .nxt(begin_nxt)
  );

  // Read pointer follows the head in normal mode, reloads on rewind/leave,
  // and wraps back to the oldest entry when it would reach the write pointer.
  fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_rd (
    .clk(clk), .reset(reset), .inc(adv), .load(rd_load),
    .load_val(begin_nxt), .ptr(rd_ptr), .nxt(rd_nxt)
  );

  // Next fill, status and show-ahead word (bypass when the word is being written now).
  always_comb begin
    fill_nxt = fill_q;
    if (flush)
      fill_nxt = '0;
    else if (wr_acc && !pop)
      fill_nxt = fill_q + FW'(1);
    else if (pop && !wr_acc)
      fill_nxt = fill_q - FW'(1);
    st_nxt = status_of(fill_nxt);
    ov_nxt = !flush && !leave && (fill_nxt != '0);
    if (flush)
      od_nxt = '0;
    else if (wr_acc && (rd_nxt == wr_ptr))
      od_nxt = inData;
    else
      od_nxt = mem[rd_nxt];
  end

  // Storage write; contents are not cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush)
      mem[wr_ptr] <= inData;
  end

  // Fill, status, output stage and mode history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_q   <= '0;
      st_q     <= status_of('0);
      outValid <= 1'b0;
      outData  <= '0;
      mode_q   <= 1'b0;
    end else begin
      fill_q   <= fill_nxt;
      st_q     <= st_nxt;
      outValid <= ov_nxt;
      outData  <= od_nxt;
      mode_q   <= circular;
    end
  end

`ifdef FIFO_STICKY_ERR_EN
  logic ovf_q, udf_q;

  // Sticky error flags, cleared by clearErrors, flush or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (flush || clearErrors) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (inValid && !inReady)
        ovf_q <= 1'b1;
      if (outReady && !outValid && !circular)
        udf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_clear;
  assign unused_clear = clearErrors;
  assign overflow     = 1'b0;
  assign underflow    = 1'b0;
`endif

endmodule
